// File: rtl/weight_serializer_if.sv
// weight_serializer_if: load/stream bundle between a bundle source, the serializer and the word sink
interface weight_serializer_if #(parameter int NUM_BYTES = 9);
  logic                   i_load;
  logic [8*NUM_BYTES-1:0] i_bytes;
  logic                   o_load_ready;
  logic                   o_valid;
  logic [31:0]            o_data;
  logic                   i_ready;
  logic                   o_busy;
  logic                   o_done;
  modport slave (
    input  i_load, i_bytes, i_ready,
    output o_load_ready, o_valid, o_data, o_busy, o_done
  );
  modport master (
    output i_load, i_bytes, i_ready,
    input  o_load_ready, o_valid, o_data, o_busy, o_done
  );
endinterface

// File: rtl/weight_serializer.sv
// weight_serializer: emits a NUM_BYTES-byte weight bundle as 32-bit words over valid/ready
// WSER_CHECKSUM_EN: when defined, a trailing {sum8, 24'h0} word follows the payload words.
module weight_serializer #(
  parameter int NUM_BYTES = 9
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  weight_serializer_if.slave bus
);
  localparam int NUM_WORDS = (NUM_BYTES + 3) / 4;
  localparam int PW = 32 * NUM_WORDS;
`ifdef WSER_CHECKSUM_EN
  localparam int TW = NUM_WORDS + 1;
`else
  localparam int TW = NUM_WORDS;
`endif
  localparam int SW = 32 * TW;
  localparam int CW = $clog2(TW + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, cap;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] payload;
  logic          hs, last;
  // byte0 lands in the MSBs; unused low bytes of the last word stay zero
  assign payload = PW'(bus.i_bytes) << (PW - 8 * NUM_BYTES);
`ifdef WSER_CHECKSUM_EN
  logic [7:0] sum;
  // mod-256 byte sum of the bundle, taken from the bus on the capture edge
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_BYTES; k++) sum = sum + bus.i_bytes[8*k +: 8];
  end
  assign cap = {payload, sum, 24'h0};
`else
  assign cap = payload;
`endif
  assign hs   = bus.o_valid & bus.i_ready;
  assign last = cnt_q == CW'(TW - 1);
  assign bus.o_load_ready = state_q == S_IDLE;
  assign bus.o_valid      = state_q == S_SEND;
  assign bus.o_busy       = state_q == S_SEND || state_q == S_DONE;
  assign bus.o_done       = state_q == S_DONE;
  assign bus.o_data       = sr_q[SW-1 -: 32];
  // capture in idle, shift one word out per handshake; the register drains to zero after the last word
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && bus.i_load) begin
      state_d = S_SEND;
      sr_d    = cap;
      cnt_d   = '0;
    end else if (state_q == S_SEND && hs) begin
      sr_d    = sr_q << 32;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? S_DONE : S_SEND;
    end else if (state_q != S_SEND) begin
      state_d = S_IDLE;
    end
  end
  // state registers; reset aborts any transfer in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_weight_serializer.sv
// tb_weight_serializer: directed and randomized bundles checked against a byte-level word model
module tb_weight_serializer;
  localparam int NB = 9;
  localparam int NW = (NB + 3) / 4;
`ifdef WSER_CHECKSUM_EN
  localparam int TW = NW + 1;
`else
  localparam int TW = NW;
`endif
  typedef logic [8*NB-1:0] bundle_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  weight_serializer_if #(.NUM_BYTES(NB)) bus ();
  weight_serializer #(.NUM_BYTES(NB)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] byte_of(bundle_t b, int k);
    return b[8*(NB-k)-1 -: 8];
  endfunction
  function automatic logic [31:0] exp_word(bundle_t b, int w);
    logic [31:0] r = '0;
    logic [7:0] s = '0;
    for (int k = 0; k < NB; k++) s += byte_of(b, k);
    if (w >= NW) return {s, 24'h0};
    for (int j = 0; j < 4; j++) r = {r[23:0], (4*w + j < NB) ? byte_of(b, 4*w + j) : 8'h00};
    return r;
  endfunction
  function automatic bundle_t seq(logic [7:0] base);
    bundle_t r = '0;
    for (int k = 0; k < NB; k++) r[8*(NB-k)-1 -: 8] = base + 8'(k);
    return r;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_bundle(bundle_t b, int stall);
    int w = 0;
    int cyc = 0;
    bit rdy;
    chk("load_ready", 32'(bus.o_load_ready), 1);
    bus.i_load = 1'b1;
    bus.i_bytes = b;
    @(negedge clk);
    while (w < TW && cyc < 400) begin
      chk("valid", 32'(bus.o_valid), 1);
      chk("busy", 32'(bus.o_busy), 1);
      chk("word", bus.o_data, exp_word(b, w));
      rdy = $urandom_range(99) >= stall;
      bus.i_ready = rdy;
      bus.i_load = 1'($urandom_range(1));
      bus.i_bytes = bundle_t'({$urandom, $urandom, $urandom});
      @(negedge clk);
      cyc++;
      if (rdy) w++;
    end
    if (stall == 0) chk("burst_len", 32'(cyc), TW);
    chk("words_sent", 32'(w), TW);
    bus.i_ready = 1'b0;
    bus.i_load = 1'b0;
    chk("done_valid", 32'(bus.o_valid), 0);
    chk("done_data", bus.o_data, 0);
    chk("done_pulse", 32'(bus.o_done), 1);
    chk("done_lr", 32'(bus.o_load_ready), 0);
    @(negedge clk);
    chk("idle_done", 32'(bus.o_done), 0);
    chk("idle_lr", 32'(bus.o_load_ready), 1);
    chk("idle_busy", 32'(bus.o_busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bundle_t b1, b2, bx;
    bit v;
    bus.i_load = 1'b0;
    bus.i_bytes = '0;
    bus.i_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_lr", 32'(bus.o_load_ready), 1);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_bundle(seq(8'h01), 0);
    run_bundle(seq(8'h01), 60);
    run_bundle(seq(8'h01), 30);
    bus.i_load = 1'b1;
    bus.i_bytes = seq(8'h01);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
    chk("pre_rst_w0", bus.o_data, exp_word(seq(8'h01), 0));
    @(negedge clk);
    chk("pre_rst_w1", bus.o_data, exp_word(seq(8'h01), 1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lr", 32'(bus.o_load_ready), 1);
    chk("mid_rst_valid", 32'(bus.o_valid), 0);
    chk("mid_rst_data", bus.o_data, 0);
    chk("mid_rst_busy", 32'(bus.o_busy), 0);
    chk("mid_rst_done", 32'(bus.o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b0;
    run_bundle(seq(8'hA0), 0);
    run_bundle(seq(8'h80), 0);
    b1 = bundle_t'({$urandom, $urandom, $urandom});
    b2 = bundle_t'({$urandom, $urandom, $urandom});
    bus.i_load = 1'b1;
    bus.i_bytes = b1;
    bus.i_ready = 1'b1;
    for (int t = 0; t < 2*TW + 4; t++) begin
      @(negedge clk);
      if (t == 0) bus.i_bytes = b2;
      if (t == TW + 2) bus.i_load = 1'b0;
      v = (t < TW) || (t >= TW + 2 && t < 2*TW + 2);
      chk("b2b_valid", 32'(bus.o_valid), 32'(v));
      chk("b2b_data", bus.o_data, !v ? 32'h0 : (t < TW) ? exp_word(b1, t) : exp_word(b2, t - TW - 2));
      chk("b2b_done", 32'(bus.o_done), 32'(t == TW || t == 2*TW + 2));
      chk("b2b_lr", 32'(bus.o_load_ready), 32'(t == TW + 1 || t == 2*TW + 3));
    end
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bx = bundle_t'({$urandom, $urandom, $urandom});
      run_bundle(bx, int'($urandom_range(70)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
